pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Owns the PC/nPC pair of the SPARC-subset core and sequences them every retired instruction.
//  Resolves delayed control transfer, including annulled delay slots, jmpl, trap entry and rett.
//  Sits between control unit / branch logic and the fetch path; pc drives instruction memory.
// PARAMETERS
//  RESET_PC    32'h00000000  PC after reset; nPC resets to RESET_PC+4
//  TRAP_CYCLES 2             cycles in trap entry (SAVE then JUMP); fixed, not tunable
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous, active-low reset
//  advance      in   1   current instruction retires this cycle
//  stall        in   1   hold PC/nPC; blocks advance, not trap_req
//  br_valid     in   1   retiring instruction is a Bicc
//  br_taken     in   1   condition evaluated true
//  br_always    in   1   branch is ba (unconditional)
//  br_annul     in   1   annul bit (a) of the branch
//  br_target    in   32  branch target address
//  jmpl_valid   in   1   retiring instruction is jmpl/call
//  jmpl_target  in   32  jump target address
//  trap_req     in   1   level; take trap at next RUN cycle
//  trap_vector  in   32  trap handler address
//  rett_valid   in   1   retiring instruction is rett
//  pc           out  32  current PC
//  npc          out  32  current nPC
//  pc_valid     out  1   pc is a fetchable instruction address
//  annul_pulse  out  1   1-cycle pulse: a delay slot was skipped
//  align_err    out  1   1-cycle pulse: target had bits[1:0] != 0
//  trap_ack     out  1   1-cycle pulse in the JUMP state
//  saved_pc     out  32  PC captured at trap entry
//  saved_npc    out  32  nPC captured at trap entry
// BEHAVIOUR
//  Reset (async, any state): state=BOOT, pc=RESET_PC, npc=RESET_PC+4, saved_*=0, all pulses 0, pc_valid=0.
//  States: BOOT -> RUN (unconditional, 1 cycle); RUN -> SAVE on trap_req; SAVE -> JUMP -> RUN.
//  pc_valid=1 only in RUN. pc/npc/saved_* are registered; all effects are visible the cycle after the edge.
//  RUN, priority per cycle (highest first):
//   1 trap_req: ignore advance; next=SAVE; pc/npc held.
//   2 stall: hold everything; no pulses.
//   3 advance & rett_valid: pc<=saved_pc, npc<=saved_npc.
//   4 advance & jmpl_valid: pc<=npc, npc<=jmpl_target (wins over br_valid).
//   5 advance & br_valid:
//      taken & !(always&annul): pc<=npc, npc<=br_target
//      always & annul:          pc<=br_target, npc<=br_target+4, annul_pulse
//      !taken & annul:          pc<=npc+4, npc<=npc+8, annul_pulse
//      !taken & !annul:         pc<=npc, npc<=npc+4
//   6 advance only: pc<=npc, npc<=npc+4.   7 no advance: hold.
//  SAVE: saved_pc<=pc, saved_npc<=npc. JUMP: pc<=trap_vector, npc<=trap_vector+4, trap_ack=1.
//  Targets and trap_vector: bits[1:0] forced to 0 before use; align_err pulses if any bit was set.
//  Adds are mod 2^32: npc=32'hFFFFFFFC +4 -> 0, no flag.
//  trap_req held high through SAVE/JUMP is not re-taken until the first RUN cycle after JUMP.
//  advance/rett/br/jmpl inputs are ignored outside RUN.
// TESTING
//  Reset, 4 advances -> pc 0,4,8,C,10, npc one step ahead; pc_valid=0 in BOOT cycle.
//  At pc=8: bne taken, target 0x100, a=0 -> pc=C,npc=100, then pc=100,npc=104.
//  At pc=8: ba,a target 0x200 -> pc=200,npc=204,annul_pulse=1; bne untaken,a=1 -> pc=10,npc=14.
//  trap_req at pc=20,npc=24, vector 0x800 -> SAVE, JUMP with trap_ack, pc=800,npc=804,
//   saved 20/24; later rett -> pc=20,npc=24.
//  stall with advance for 3 cycles -> pc/npc unchanged; trap_req during stall still taken.
//  jmpl_target=0x103 -> npc=100 and align_err pulse; npc=FFFFFFFC sequential -> wraps to 0; reset_n low mid-JUMP -> BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : PC/nPC sequencing with delayed branches, annulled delay slots,
//            jmpl, two-cycle trap entry (SAVE, JUMP) and rett.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  input  logic        jmpl_valid,
  input  logic [31:0] jmpl_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        rett_valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        pc_valid,
  output logic        annul_pulse,
  output logic        align_err,
  output logic        trap_ack,
  output logic [31:0] saved_pc,
  output logic [31:0] saved_npc
);

  localparam logic [31:0] c_step = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_SAVE = 2'd2,
    S_JUMP = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_npc, r_saved_pc, r_saved_npc;
  logic [31:0] w_pc_nxt, w_npc_nxt, w_saved_pc_nxt, w_saved_npc_nxt;
  logic        r_annul, r_align, w_annul_nxt, w_align_nxt;

  logic [31:0] w_br_tgt, w_jmpl_tgt, w_vec_tgt;
  logic        w_br_mis, w_jmpl_mis, w_vec_mis, w_taken;

  // Low address bits are dropped before any target is used.
  assign w_br_tgt   = {br_target[31:2], 2'b00};
  assign w_jmpl_tgt = {jmpl_target[31:2], 2'b00};
  assign w_vec_tgt  = {trap_vector[31:2], 2'b00};
  assign w_br_mis   = |br_target[1:0];
  assign w_jmpl_mis = |jmpl_target[1:0];
  assign w_vec_mis  = |trap_vector[1:0];
  assign w_taken    = br_taken | br_always;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_npc       <= RESET_PC + c_step;
      r_saved_pc  <= 32'h0;
      r_saved_npc <= 32'h0;
      r_annul     <= 1'b0;
      r_align     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_npc       <= w_npc_nxt;
      r_saved_pc  <= w_saved_pc_nxt;
      r_saved_npc <= w_saved_npc_nxt;
      r_annul     <= w_annul_nxt;
      r_align     <= w_align_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_npc_nxt       = r_npc;
    w_saved_pc_nxt  = r_saved_pc;
    w_saved_npc_nxt = r_saved_npc;
    w_annul_nxt     = 1'b0;
    w_align_nxt     = 1'b0;
    unique case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (trap_req) begin
          w_state_nxt = S_SAVE;
        end else if (stall) begin
          w_state_nxt = S_RUN;
        end else if (advance) begin
          if (rett_valid) begin
            w_pc_nxt  = r_saved_pc;
            w_npc_nxt = r_saved_npc;
          end else if (jmpl_valid) begin
            w_pc_nxt    = r_npc;
            w_npc_nxt   = w_jmpl_tgt;
            w_align_nxt = w_jmpl_mis;
          end else if (br_valid) begin
            if (br_always && br_annul) begin
              // ba,a: the delay slot is skipped and the target executes next
              w_pc_nxt    = w_br_tgt;
              w_npc_nxt   = w_br_tgt + c_step;
              w_annul_nxt = 1'b1;
              w_align_nxt = w_br_mis;
            end else if (w_taken) begin
              w_pc_nxt    = r_npc;
              w_npc_nxt   = w_br_tgt;
              w_align_nxt = w_br_mis;
            end else if (br_annul) begin
              w_pc_nxt    = r_npc + c_step;
              w_npc_nxt   = r_npc + (c_step << 1);
              w_annul_nxt = 1'b1;
            end else begin
              w_pc_nxt  = r_npc;
              w_npc_nxt = r_npc + c_step;
            end
          end else begin
            w_pc_nxt  = r_npc;
            w_npc_nxt = r_npc + c_step;
          end
        end
      end
      S_SAVE: begin
        w_saved_pc_nxt  = r_pc;
        w_saved_npc_nxt = r_npc;
        w_state_nxt     = S_JUMP;
      end
      S_JUMP: begin
        w_pc_nxt    = w_vec_tgt;
        w_npc_nxt   = w_vec_tgt + c_step;
        w_align_nxt = w_vec_mis;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign pc          = r_pc;
  assign npc         = r_npc;
  assign saved_pc    = r_saved_pc;
  assign saved_npc   = r_saved_npc;
  assign annul_pulse = r_annul;
  assign align_err   = r_align;
  assign pc_valid    = (r_state == S_RUN);
  assign trap_ack    = (r_state == S_JUMP);

endmodule
`default_nettype wire
